// File: rtl/registers_mp_pkg.sv
// Shared register-file constants and helpers for the registers_mp slice.
// Holds default widths plus the MIPS ABI register indices ($v0, $a0, $ra).
package registers_mp_pkg;

  localparam int DEF_DW   = 32;
  localparam int DEF_NREG = 32;

  localparam int REG_V0 = 2;
  localparam int REG_A0 = 4;
  localparam int REG_RA = 31;

  // Address width for n registers, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/registers_mp_if.sv
// Decode/writeback bus of the register file: read ports, write ports, taps.
// master drives addresses/writes/issues; slave returns read data/busy/taps.
interface registers_mp_if
  import registers_mp_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = 5,
  parameter int NUM_RD = 2
);

  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          link_en;
  logic [DW-1:0] link_data;

  logic          iss_en;
  logic [AW-1:0] iss_addr;

  logic [DW-1:0] v0;
  logic [DW-1:0] a0;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output link_en, link_data, iss_en, iss_addr,
    input  rd_data, rd_busy, v0, a0
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  link_en, link_data, iss_en, iss_addr,
    output rd_data, rd_busy, v0, a0
  );

endinterface

// File: rtl/registers_mp_reg_scoreboard.sv
// Per-register busy bits with two clear ports, one set port, NUM_RD lookups.
// Ports: clk, rst (async high), clr_a/clr_b (+addr), set_en/set_addr, lk_addr -> lk_busy.
module reg_scoreboard
  import registers_mp_pkg::*;
#(
  parameter int NREG     = DEF_NREG,
  parameter int AW       = addr_w(NREG),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_a,
  input  logic [AW-1:0]        clr_a_addr,
  input  logic                 clr_b,
  input  logic [AW-1:0]        clr_b_addr,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr,
  input  logic [NUM_RD*AW-1:0] lk_addr,
  output logic [NUM_RD-1:0]    lk_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] view;

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (clr_a) clr_vec[clr_a_addr] = 1'b1;
    if (clr_b) clr_vec[clr_b_addr] = 1'b1;
    if (set_en) set_vec[set_addr] = 1'b1;
    if (ZERO_REG != 0) set_vec[0] = 1'b0;
  end

  // Set is OR-ed after the clear: a new producer beats a completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr_vec) | set_vec;
  end

  // Completions are visible to lookups in their own cycle; issues are not.
  assign view = (BYPASS != 0) ? (busy & ~clr_vec) : busy;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_lk
    assign lk_busy[i] = view[lk_addr[i*AW +: AW]];
  end

endmodule

// File: rtl/registers_mp.sv
// Multi-read-port register file with link write port, scoreboard, v0/a0 taps.
// Ports: clk, rst (async high), bus (registers_mp_if.slave).
module registers_mp
  import registers_mp_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int NREG     = DEF_NREG,
  parameter int AW       = addr_w(NREG),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int LINK_REG = REG_RA,
  parameter int V0_REG   = REG_V0,
  parameter int A0_REG   = REG_A0
) (
  input logic           clk,
  input logic           rst,
  registers_mp_if.slave bus
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic [DW-1:0] regs [NREG];
  logic          wr_ok;
  logic          link_ok;

  assign wr_ok   = bus.wr_en &&
                   !(ZERO_REG != 0 && bus.wr_addr == '0);
  assign link_ok = bus.link_en &&
                   !(ZERO_REG != 0 && LINK_A == '0);

  // Link write is applied last so it wins a same-register collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      if (wr_ok)   regs[bus.wr_addr] <= bus.wr_data;
      if (link_ok) regs[LINK_A]      <= bus.link_data;
    end
  end

  reg_scoreboard #(
    .NREG     (NREG),
    .AW       (AW),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .clr_a      (bus.wr_en),
    .clr_a_addr (bus.wr_addr),
    .clr_b      (bus.link_en),
    .clr_b_addr (LINK_A),
    .set_en     (bus.iss_en),
    .set_addr   (bus.iss_addr),
    .lk_addr    (bus.rd_addr),
    .lk_busy    (bus.rd_busy)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] data;

    assign a = bus.rd_addr[i*AW +: AW];

    always_comb begin
      data = regs[a];
      if (BYPASS != 0) begin
        if (bus.link_en && a == LINK_A)
          data = bus.link_data;
        else if (bus.wr_en && a == bus.wr_addr)
          data = bus.wr_data;
      end
      // Hardwired zero overrides any forwarded value.
      if (ZERO_REG != 0 && a == '0) data = '0;
    end

    assign bus.rd_data[i*DW +: DW] = data;
  end

  assign bus.v0 = regs[V0_REG];
  assign bus.a0 = regs[A0_REG];

endmodule

// File: tb/tb_registers_mp.sv
// Self-checking bench for registers_mp: bypass, no-bypass and 3-port/64-bit builds.
// Directed cases first, then randomized traffic against a register/busy model.
module tb_registers_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  registers_mp_if #(.DW(32), .AW(5), .NUM_RD(2)) m_if ();
  registers_mp_if #(.DW(32), .AW(5), .NUM_RD(2)) nb_if ();
  registers_mp_if #(.DW(64), .AW(5), .NUM_RD(3)) w_if ();

  registers_mp dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  registers_mp #(.BYPASS(0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (nb_if)
  );

  registers_mp #(.DW(64), .NUM_RD(3)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (w_if)
  );

  assign nb_if.rd_addr   = m_if.rd_addr;
  assign nb_if.wr_en     = m_if.wr_en;
  assign nb_if.wr_addr   = m_if.wr_addr;
  assign nb_if.wr_data   = m_if.wr_data;
  assign nb_if.link_en   = m_if.link_en;
  assign nb_if.link_data = m_if.link_data;
  assign nb_if.iss_en    = m_if.iss_en;
  assign nb_if.iss_addr  = m_if.iss_addr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mr [32];
  bit          mb [32];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mr[r] = '0;
      mb[r] = 1'b0;
    end
  endtask

  function automatic logic [31:0] ref_rd(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && m_if.link_en && a == 31) return m_if.link_data;
    if (byp && m_if.wr_en && a == int'(m_if.wr_addr)) return m_if.wr_data;
    return mr[a];
  endfunction

  function automatic bit ref_busy(input int a, input bit byp);
    bit done;
    done = (m_if.wr_en && a == int'(m_if.wr_addr)) ||
           (m_if.link_en && a == 31);
    return byp ? (mb[a] && !done) : mb[a];
  endfunction

  task automatic check_outputs();
    int a;
    for (int p = 0; p < 2; p++) begin
      a = int'(m_if.rd_addr[p*5 +: 5]);
      chk("byp_rd_data", 64'(m_if.rd_data[p*32 +: 32]), 64'(ref_rd(a, 1'b1)));
      chk("byp_rd_busy", 64'(m_if.rd_busy[p]), 64'(ref_busy(a, 1'b1)));
      chk("nb_rd_data", 64'(nb_if.rd_data[p*32 +: 32]), 64'(ref_rd(a, 1'b0)));
      chk("nb_rd_busy", 64'(nb_if.rd_busy[p]), 64'(ref_busy(a, 1'b0)));
    end
    chk("byp_v0", 64'(m_if.v0), 64'(mr[2]));
    chk("byp_a0", 64'(m_if.a0), 64'(mr[4]));
    chk("nb_v0", 64'(nb_if.v0), 64'(mr[2]));
    chk("nb_a0", 64'(nb_if.a0), 64'(mr[4]));
  endtask

  // Advance one edge and apply the architectural effect of this cycle.
  task automatic tick();
    int wa;
    int ia;
    @(posedge clk);
    wa = int'(m_if.wr_addr);
    ia = int'(m_if.iss_addr);
    if (m_if.wr_en && wa != 0) mr[wa] = m_if.wr_data;
    if (m_if.link_en) mr[31] = m_if.link_data;
    if (m_if.wr_en) mb[wa] = 1'b0;
    if (m_if.link_en) mb[31] = 1'b0;
    if (m_if.iss_en && ia != 0) mb[ia] = 1'b1;
    #1;
  endtask

  task automatic step();
    #3;
    check_outputs();
    tick();
  endtask

  task automatic idle();
    m_if.wr_en     = 1'b0;
    m_if.wr_addr   = '0;
    m_if.wr_data   = '0;
    m_if.link_en   = 1'b0;
    m_if.link_data = '0;
    m_if.iss_en    = 1'b0;
    m_if.iss_addr  = '0;
    w_if.wr_en     = 1'b0;
    w_if.wr_addr   = '0;
    w_if.wr_data   = '0;
    w_if.link_en   = 1'b0;
    w_if.link_data = '0;
    w_if.iss_en    = 1'b0;
    w_if.iss_addr  = '0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a0);
    m_if.rd_addr = {a1, a0};
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    m_if.wr_en   = 1'b1;
    m_if.wr_addr = a;
    m_if.wr_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rd(5'd0, 5'd0);
    w_if.rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    rd(5'd2, 5'd5);
    step();

    // Mid-run asynchronous reset.
    wr(5'd5, 32'hDEADBEEF);
    step();
    wr(5'd2, 32'h22);
    step();
    wr(5'd4, 32'h44);
    m_if.iss_en   = 1'b1;
    m_if.iss_addr = 5'd8;
    step();
    idle();
    rd(5'd8, 5'd5);
    step();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_rd_data0", 64'(m_if.rd_data[31:0]), 64'h0);
    chk("rst_rd_data1", 64'(m_if.rd_data[63:32]), 64'h0);
    chk("rst_rd_busy", 64'(m_if.rd_busy), 64'h0);
    chk("rst_v0", 64'(m_if.v0), 64'h0);
    chk("rst_a0", 64'(m_if.a0), 64'h0);
    wr(5'd5, 32'h77);
    m_if.iss_en   = 1'b1;
    m_if.iss_addr = 5'd9;
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle();
    rd(5'd9, 5'd5);
    #2;
    chk("rst_discard_wr", 64'(m_if.rd_data[31:0]), 64'h0);
    chk("rst_discard_iss", 64'(m_if.rd_busy[1]), 64'h0);
    check_outputs();
    tick();

    // Same-cycle bypass vs. next-cycle visibility.
    wr(5'd2, 32'h11);
    rd(5'd0, 5'd2);
    #3;
    chk("byp_same_cycle", 64'(m_if.rd_data[31:0]), 64'h11);
    chk("nb_same_cycle", 64'(nb_if.rd_data[31:0]), 64'h0);
    chk("v0_not_yet", 64'(m_if.v0), 64'h0);
    check_outputs();
    tick();
    idle();
    #3;
    chk("v0_next", 64'(m_if.v0), 64'h11);
    chk("nb_next", 64'(nb_if.rd_data[31:0]), 64'h11);
    check_outputs();
    tick();

    // Link beats main write on $ra.
    wr(5'd31, 32'hAAAA);
    m_if.link_en   = 1'b1;
    m_if.link_data = 32'h400;
    rd(5'd0, 5'd31);
    #3;
    chk("link_byp", 64'(m_if.rd_data[31:0]), 64'h400);
    check_outputs();
    tick();
    idle();
    #3;
    chk("link_stored", 64'(m_if.rd_data[31:0]), 64'h400);
    chk("link_stored_nb", 64'(nb_if.rd_data[31:0]), 64'h400);
    check_outputs();
    tick();

    // Register zero ignores writes and issues.
    wr(5'd0, 32'hFFFF);
    m_if.iss_en   = 1'b1;
    m_if.iss_addr = 5'd0;
    rd(5'd0, 5'd0);
    #3;
    chk("zero_byp", 64'(m_if.rd_data[31:0]), 64'h0);
    chk("zero_busy_now", 64'(m_if.rd_busy[0]), 64'h0);
    check_outputs();
    tick();
    idle();
    #3;
    chk("zero_stored", 64'(m_if.rd_data[31:0]), 64'h0);
    chk("zero_busy", 64'(m_if.rd_busy[0]), 64'h0);
    check_outputs();
    tick();

    // Scoreboard set/clear ordering on reg 8.
    m_if.iss_en   = 1'b1;
    m_if.iss_addr = 5'd8;
    rd(5'd0, 5'd8);
    #3;
    chk("iss_not_same", 64'(m_if.rd_busy[0]), 64'h0);
    check_outputs();
    tick();
    idle();
    #3;
    chk("iss_busy", 64'(m_if.rd_busy[0]), 64'h1);
    check_outputs();
    tick();
    wr(5'd8, 32'h88);
    #3;
    chk("clr_byp", 64'(m_if.rd_busy[0]), 64'h0);
    chk("clr_nb", 64'(nb_if.rd_busy[0]), 64'h1);
    check_outputs();
    tick();
    m_if.iss_en   = 1'b1;
    m_if.iss_addr = 5'd8;
    step();
    idle();
    wr(5'd8, 32'h99);
    m_if.iss_en   = 1'b1;
    m_if.iss_addr = 5'd8;
    step();
    idle();
    #3;
    chk("iss_wins", 64'(m_if.rd_busy[0]), 64'h1);
    check_outputs();
    tick();

    // Three-port 64-bit build.
    w_if.wr_en   = 1'b1;
    w_if.wr_addr = 5'd3;
    w_if.wr_data = 64'h0123_4567_89AB_CDEF;
    step();
    w_if.wr_addr = 5'd7;
    w_if.wr_data = 64'hFEDC_BA98_7654_3210;
    step();
    w_if.wr_addr = 5'd9;
    w_if.wr_data = 64'hA5A5_5A5A_C3C3_3C3C;
    w_if.rd_addr = {5'd3, 5'd7, 5'd9};
    #3;
    chk("w_port0_byp", w_if.rd_data[63:0], 64'hA5A5_5A5A_C3C3_3C3C);
    chk("w_port1", w_if.rd_data[127:64], 64'hFEDC_BA98_7654_3210);
    chk("w_port2", w_if.rd_data[191:128], 64'h0123_4567_89AB_CDEF);
    check_outputs();
    tick();
    idle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] ra [2];
      m_if.wr_en     = 1'($urandom_range(0, 1));
      m_if.wr_addr   = 5'($urandom_range(0, 31));
      m_if.wr_data   = $urandom;
      m_if.link_en   = ($urandom_range(0, 3) == 0);
      m_if.link_data = $urandom;
      m_if.iss_en    = ($urandom_range(0, 2) == 0);
      m_if.iss_addr  = 5'($urandom_range(0, 15));
      for (int p = 0; p < 2; p++) begin
        case ($urandom_range(0, 3))
          0: ra[p] = m_if.wr_addr;
          1: ra[p] = 5'($urandom_range(0, 15));
          2: ra[p] = 5'd31;
          default: ra[p] = 5'($urandom_range(0, 31));
        endcase
      end
      rd(ra[1], ra[0]);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
